// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between fetch_unit (master) and imem (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-entry output buffer plus pending word, with redirect kill.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic                out_valid,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_ir
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [15:0]         perf_dropped
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_BUF, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_ir_q, out_ir_d;
  logic [31:0] pend_q, pend_d;
  logic        consume;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_ir_d    = out_ir_q;
    pend_d      = pend_q;
    consume     = out_valid_q && !stall;

    if (consume) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (!imem.imem_ack) state_d = DROP;
        end else if (imem.imem_ack) begin
          if (out_valid_q && stall) begin
            pend_d  = imem.imem_rdata;
            state_d = WAIT_BUF;
          end else begin
            out_valid_d = 1'b1;
            out_pc_d    = pc_q + 32'd1;
            out_ir_d    = imem.imem_rdata;
            pc_d        = pc_q + 32'd1;
          end
        end
      end
      WAIT_BUF: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          pend_d  = 32'd0;
          state_d = REQ;
        end else if (!stall) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q + 32'd1;
          out_ir_d    = pend_q;
          pc_d        = pc_q + 32'd1;
          state_d     = REQ;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (imem.imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) out_valid_d = 1'b0;

    // The outstanding address must stay put until the stale ack returns.
    addr_d = (state_d == DROP) ? addr_q : pc_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'd0;
      out_ir_q    <= 32'd0;
      pend_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_ir_q    <= out_ir_d;
      pend_q      <= pend_d;
    end
  end

  assign imem.imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr = addr_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_ir         = out_ir_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_dropped_q, perf_dropped_d;
  logic [1:0]  drop_inc;

  // A single redirect can kill both the buffer and the pending word.
  always_comb begin
    drop_inc = 2'd0;
    if (imem.imem_ack && ((state_q == DROP) || ((state_q == REQ) && redirect_valid)))
      drop_inc = drop_inc + 2'd1;
    if (redirect_valid && (state_q == WAIT_BUF))
      drop_inc = drop_inc + 2'd1;
    if (redirect_valid && out_valid_q && stall)
      drop_inc = drop_inc + 2'd1;
    perf_fetched_d = perf_fetched_q + {31'd0, consume};
    perf_dropped_d = perf_dropped_q + {14'd0, drop_inc};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= 32'd0;
      perf_dropped_q <= 16'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a queue of expected {out_pc, out_ir}
// is pushed when an ack is accepted and popped on every consume edge.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [15:0] perf_dropped;
`endif

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'd0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_ir         (out_ir)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  int          exp_fetched = 0;
  int          exp_dropped = 0;
  logic [31:0] exp_pc;
  logic [31:0] hold_ir;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Memory model: answers whatever address the DUT currently presents.
  task automatic apply_stimulus(input logic ack, input logic st, input logic rv,
                                input logic [31:0] rpc);
    imem.imem_ack   = ack;
    stall           = st;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem.imem_rdata = ack ? data_for(imem.imem_addr) : 32'h0;
  endtask

  task automatic push_expected(input logic [31:0] pc);
    logic [31:0] npc;
    npc = pc + 32'd1;
    sb_q.push_back({npc, data_for(pc)});
  endtask

  // Scores a consume on the coming edge, then advances one clock.
  task automatic cycle();
    logic [63:0] e;
    if (out_valid === 1'b1 && stall === 1'b0) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_consume observed out_pc=%h expected no valid", out_pc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        exp_fetched++;
        check_output("consume_pc", out_pc, e[63:32]);
        check_output("consume_ir", out_ir, e[31:0]);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #2;
    check_output("reset_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_pc",    out_pc, 32'd0);
    check_output("reset_ir",    out_ir, 32'd0);
    check_output("reset_req",   {31'd0, imem.imem_req}, 32'd0);
    check_output("reset_addr",  imem.imem_addr, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_output("idle_req", {31'd0, imem.imem_req}, 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("idle_ack_ignored", {31'd0, out_valid}, 32'd0);
    check_output("first_req", {31'd0, imem.imem_req}, 32'd1);

    // Back-to-back single-cycle acks
    exp_pc = 32'd0;
    for (int i = 0; i < 6; i++) begin
      check_output("stream_addr", imem.imem_addr, exp_pc);
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
      push_expected(exp_pc);
      exp_pc++;
      cycle();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("stream_drained", 32'(sb_q.size()), 32'd0);
    check_output("stream_valid_low", {31'd0, out_valid}, 32'd0);

    // Stall while an ack arrives: pending word parks in WAIT_BUF
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    push_expected(exp_pc);
    hold_ir = data_for(exp_pc);
    exp_pc++;
    cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    push_expected(exp_pc);
    exp_pc++;
    cycle();
    check_output("waitbuf_req", {31'd0, imem.imem_req}, 32'd0);
    check_output("stall_hold_ir", out_ir, hold_ir);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
      cycle();
      check_output("waitbuf_req_held", {31'd0, imem.imem_req}, 32'd0);
      check_output("stall_hold_ir", out_ir, hold_ir);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("unstall_req", {31'd0, imem.imem_req}, 32'd1);
    check_output("unstall_addr", imem.imem_addr, exp_pc);
    check_output("unstall_valid", {31'd0, out_valid}, 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("stall_drained", 32'(sb_q.size()), 32'd0);

    // Redirect with request outstanding while a stalled buffer is flushed
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_pc++;
    cycle();
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h30);
    exp_dropped++;
    cycle();
    check_output("drop_valid_cleared", {31'd0, out_valid}, 32'd0);
    check_output("drop_req", {31'd0, imem.imem_req}, 32'd1);
    check_output("drop_addr_held", imem.imem_addr, exp_pc);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h40);
    cycle();
    check_output("drop_addr_held2", imem.imem_addr, exp_pc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_dropped++;
    cycle();
    exp_pc = 32'h40;
    check_output("drop_stale_valid", {31'd0, out_valid}, 32'd0);
    check_output("redirect_addr", imem.imem_addr, exp_pc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    push_expected(exp_pc);
    exp_pc++;
    cycle();
    check_output("redirect_returns", {31'd0, out_valid}, 32'd1);

    // Redirect coincident with ack
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h100);
    exp_dropped++;
    cycle();
    exp_pc = 32'h100;
    check_output("redir_ack_valid", {31'd0, out_valid}, 32'd0);
    check_output("redir_ack_addr", imem.imem_addr, exp_pc);
    check_output("redir_ack_req", {31'd0, imem.imem_req}, 32'd1);

    // Redirect while a word is pending
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    push_expected(exp_pc);
    exp_pc++;
    cycle();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0);
    exp_pc++;
    cycle();
    check_output("wb_redir_req_low", {31'd0, imem.imem_req}, 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h200);
    exp_dropped++;
    cycle();
    exp_pc = 32'h200;
    check_output("wb_redir_valid", {31'd0, out_valid}, 32'd0);
    check_output("wb_redir_req", {31'd0, imem.imem_req}, 32'd1);
    check_output("wb_redir_addr", imem.imem_addr, exp_pc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    push_expected(exp_pc);
    exp_pc++;
    cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("wb_drained", 32'(sb_q.size()), 32'd0);

    // PC wrap at the top of the address space
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle();
    check_output("wrap_drop_addr", imem.imem_addr, exp_pc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    exp_dropped++;
    cycle();
    exp_pc = 32'hFFFF_FFFF;
    check_output("wrap_addr", imem.imem_addr, exp_pc);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    push_expected(exp_pc);
    exp_pc = exp_pc + 32'd1;
    cycle();
    check_output("wrap_out_pc", out_pc, 32'd0);
    check_output("wrap_next_addr", imem.imem_addr, exp_pc);
`ifdef FETCH_PERF_CNT_EN
    check_output("perf_dropped", {16'd0, perf_dropped}, 32'(exp_dropped));
    check_output("perf_fetched", perf_fetched, 32'(exp_fetched));
`endif

    // Asynchronous reset mid-request, ack on the release cycle
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_valid", {31'd0, out_valid}, 32'd0);
    check_output("async_pc", out_pc, 32'd0);
    check_output("async_ir", out_ir, 32'd0);
    check_output("async_req", {31'd0, imem.imem_req}, 32'd0);
    check_output("async_addr", imem.imem_addr, 32'd0);
    exp_fetched = 0;
    exp_dropped = 0;
`ifdef FETCH_PERF_CNT_EN
    check_output("perf_reset_dropped", {16'd0, perf_dropped}, 32'd0);
    check_output("perf_reset_fetched", perf_fetched, 32'd0);
`endif
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("release_ack_ignored", {31'd0, out_valid}, 32'd0);
    check_output("restart_req", {31'd0, imem.imem_req}, 32'd1);
    check_output("restart_addr", imem.imem_addr, 32'd0);
    exp_pc = 32'd0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0);
    push_expected(exp_pc);
    exp_pc++;
    cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
    cycle();
    check_output("restart_drained", 32'(sb_q.size()), 32'd0);
    check_output("restart_next_addr", imem.imem_addr, exp_pc);
`ifdef FETCH_PERF_CNT_EN
    check_output("perf_final_fetched", perf_fetched, 32'(exp_fetched));
    check_output("perf_final_dropped", {16'd0, perf_dropped}, 32'(exp_dropped));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0, word address loaded into the PC on reset.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hazard stall; the F/D latch is enabled only when low.
REQ-005 redirect_valid  input  1  branch/jump taken, wrong-path fetch must be killed.
REQ-006 redirect_pc  input  32  word address of the redirect target.
REQ-007 imem_req  output  1  instruction-memory request, held high until imem_ack.
REQ-008 imem_addr  output  32  request word address, stable while imem_req is high.
REQ-009 imem_ack  input  1  one-cycle pulse; imem_rdata valid in that cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 out_valid  output  1  output buffer holds a valid instruction.
REQ-012 out_pc  output  32  PC+1 of the buffered instruction, for the F/D latch pc input.
REQ-013 out_ir  output  32  buffered instruction, for the F/D latch ir input.

Function
REQ-014 The buffered instruction is consumed on any edge where out_valid=1 and stall=0.
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT_BUF and DROP, and imem_req SHALL be 1 only in REQ and DROP.
REQ-016 IDLE SHALL last exactly one cycle after reset deassertion, then go to REQ with imem_addr=pc.
REQ-017 In REQ on imem_ack with redirect_valid=0 and (out_valid=0 or stall=0), the buffer SHALL load {pc+1, imem_rdata}, set out_valid=1 and pc<=pc+1, staying in REQ, so one instruction per cycle is sustained with single-cycle ack.
REQ-018 In REQ on imem_ack with out_valid=1 and stall=1, imem_rdata SHALL go to a pending register and the FSM SHALL go to WAIT_BUF.
REQ-019 In WAIT_BUF, when stall=0 the pending word SHALL move into the buffer, pc<=pc+1, and the FSM SHALL return to REQ.
REQ-020 A redirect_valid in REQ without ack SHALL set pc<=redirect_pc and go to DROP, holding imem_addr unchanged.
REQ-021 In DROP the returning ack data SHALL be discarded, then the FSM SHALL go to REQ with imem_addr=pc.
REQ-022 A redirect_valid coincident with imem_ack in REQ SHALL discard the data, set pc<=redirect_pc and stay in REQ.
REQ-023 Any redirect_valid SHALL clear out_valid on the same edge, and in WAIT_BUF SHALL also discard the pending word and go to REQ.
REQ-024 Redirect SHALL take priority over stall and over ack; the newest redirect_pc in DROP SHALL win.
REQ-025 PC arithmetic SHALL be modulo 2^32, so 32'hFFFFFFFF+1 wraps to 0.
REQ-026 The buffer SHALL hold its contents while out_valid=1 and stall=1.

Reset
REQ-027 reset_n low SHALL immediately force IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, out_valid=0, out_pc=0, out_ir=0, and clear the pending register.
REQ-028 Reset mid-transaction SHALL abandon the request, and any ack in the first cycle after release SHALL be ignored.

Configuration
REQ-029 When the macro FETCH_PERF_CNT_EN is defined, the block SHALL add outputs perf_fetched[31:0] and perf_dropped[15:0], both 0 on reset and wrapping on overflow.
REQ-030 perf_fetched SHALL increment on every consume edge, and perf_dropped on every discarded ack or cleared buffer/pending entry.
REQ-031 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset with RESET_PC=0, ack every cycle, stall=0 -> imem_addr 0,1,2,..., and out_pc 1,2,3,... with matching out_ir from the cycle after each ack.
REQ-033 stall=1 for 3 cycles while ack arrives -> WAIT_BUF entered, imem_req=0, out_ir unchanged, no instruction lost or duplicated after stall drops.
REQ-034 redirect_valid with redirect_pc=32'h40 while ack is outstanding -> DROP, stale word discarded, next imem_addr=32'h40, out_valid=0 until it returns.
REQ-035 redirect and ack in the same cycle, and redirect during WAIT_BUF -> neither word reaches out_ir, next imem_addr=redirect_pc, and perf_dropped increments by 1 for each.
REQ-036 reset_n pulsed low mid-REQ with an ack on the release cycle -> outputs zero asynchronously, the ack is ignored, fetch restarts at RESET_PC.
REQ-037 pc=32'hFFFFFFFF with consume -> out_pc=0 and next imem_addr=0.
